// File: rtl/joy_db15_tx.sv
// Device end of the DB15 UserIO joystick link: emulates the adapter's 74HC165 chain,
// capturing two player words on JOY_LOAD and shifting them out one bit per JOY_CLK rise.
module joy_db15_tx #(
  parameter int PLAYER_BITS = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = $clog2(2*PLAYER_BITS+1)
) (
  input  logic                   clk,
  input  logic                   Reset_I,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   JOY_CLK,
  input  logic                   JOY_LOAD,
  output logic                   JOY_DATA,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       bit_cnt,
  output logic                   overrun
);

  localparam int              FRAME     = 2*PLAYER_BITS;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_clk_hist;
  logic                   r_load_hist;
  logic [FRAME-1:0]       r_sr;

  logic w_clk_s;
  logic w_load_n_s;
  logic w_clk_rise;
  logic w_load;
  logic w_shift;

  // Async pins reach state only through the synchroniser chains.
  always_ff @(posedge clk or negedge Reset_I) begin
    if (!Reset_I) begin
      // NOTE: chains reset to the idle-high level so releasing reset never looks like an edge.
      r_clk_sync  <= '1;
      r_load_sync <= '1;
      r_clk_hist  <= 1'b1;
      r_load_hist <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample the previous value.
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      r_clk_hist  <= w_clk_s;
      r_load_hist <= w_load_n_s;
    end
  end

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_load_n_s = r_load_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_hist;
  assign w_load     = ~w_load_n_s;
  // A clock edge arriving in the same cycle the load releases is swallowed by the load.
  assign w_shift    = w_load_n_s & r_load_hist & w_clk_rise;

  always_ff @(posedge clk or negedge Reset_I) begin
    if (!Reset_I) begin
      r_sr       <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_load) begin
        r_sr    <= ~{joystick2, joystick1};
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (w_shift) begin
        r_sr <= {1'b1, r_sr[FRAME-1:1]};
        if (bit_cnt < FRAME_CNT) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == FRAME_CNT - 1'b1) frame_done <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign JOY_DATA = r_sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: a receiver model drives JOY_LOAD/JOY_CLK, expected wire bits
// are queued at load time and popped as each bit is sampled.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        Reset_I;
  logic [11:0] joystick1, joystick2;
  logic        JOY_CLK, JOY_LOAD;
  logic        JOY_DATA, frame_done, overrun;
  logic [4:0]  bit_cnt;

  int n_asserts = 0;
  int n_fails   = 0;
  int fd_cnt    = 0;
  bit exp_q[$];

  joy_db15_tx #(.PLAYER_BITS(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .Reset_I(Reset_I), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
    .frame_done(frame_done), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Receiver model: load, release, then sample a bit before each JOY_CLK rise.
  task automatic run_frame(input logic [11:0] j1, input logic [11:0] j2, input int nclk,
                           input int change_at, input logic [11:0] j1_new,
                           output logic [11:0] r1, output logic [11:0] r2);
    logic [23:0] word;
    logic [23:0] rx;
    int          fd_start;
    bit          e;
    rx        = '1;
    word      = ~{j2, j1};
    exp_q.delete();
    joystick1 = j1;
    joystick2 = j2;
    JOY_LOAD  = 1'b0;
    for (int i = 0; i < nclk; i++) exp_q.push_back(i < 24 ? word[i] : 1'b1);
    wait_clks(6);
    fd_start = fd_cnt;
    JOY_LOAD = 1'b1;
    wait_clks(6);
    for (int k = 0; k < nclk; k++) begin
      if (k == change_at) joystick1 = j1_new;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("bit%0d", k), 32'(JOY_DATA), 32'(e));
      check($sformatf("cnt%0d", k), 32'(bit_cnt), 32'(k < 24 ? k : 24));
      if (k < 24) rx[k] = ~JOY_DATA;
      JOY_CLK = 1'b1;
      wait_clks(6);
      JOY_CLK = 1'b0;
      wait_clks(6);
    end
    @(negedge clk);
    check("frame_done_count", 32'(fd_cnt - fd_start), 32'(nclk >= 24 ? 1 : 0));
    check("final_cnt", 32'(bit_cnt), 32'(nclk < 24 ? nclk : 24));
    check("overrun", 32'(overrun), 32'(nclk > 24 ? 1 : 0));
    r1 = rx[11:0];
    r2 = rx[23:12];
  endtask

  logic [11:0] r1, r2;

  initial begin
    Reset_I   = 1'b0;
    JOY_CLK   = 1'b0;
    JOY_LOAD  = 1'b1;
    joystick1 = '0;
    joystick2 = '0;

    // 1. reset with JOY_CLK toggling
    for (int i = 0; i < 4; i++) begin
      JOY_CLK = 1'b1; wait_clks(5);
      JOY_CLK = 1'b0; wait_clks(5);
    end
    @(negedge clk);
    check("rst_data", 32'(JOY_DATA), 32'd1);
    check("rst_cnt", 32'(bit_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fd", 32'(fd_cnt), 32'd0);
    Reset_I = 1'b1;
    wait_clks(6);
    @(negedge clk);
    check("post_rst_data", 32'(JOY_DATA), 32'd1);
    check("post_rst_fd", 32'(fd_cnt), 32'd0);

    // 2. single pressed bit at each end of the frame
    run_frame(12'h001, 12'h800, 24, -1, 12'h000, r1, r2);

    // 3. mixed pattern decoded back into player words
    run_frame(12'hA5A, 12'h3C3, 24, -1, 12'h000, r1, r2);
    check("rx_j1", 32'(r1), 32'h A5A);
    check("rx_j2", 32'(r2), 32'h 3C3);

    // 4. two extra clocks past the frame
    run_frame(12'h123, 12'h456, 26, -1, 12'h000, r1, r2);
    check("ovr_data_idle", 32'(JOY_DATA), 32'd1);
    joystick1 = 12'h00F;
    joystick2 = 12'h000;
    JOY_LOAD  = 1'b0;
    wait_clks(6);
    @(negedge clk);
    check("load_clears_ovr", 32'(overrun), 32'd0);
    check("load_clears_cnt", 32'(bit_cnt), 32'd0);
    check("load_first_bit", 32'(JOY_DATA), 32'd0);
    // clock edge coincident with load release is ignored
    JOY_LOAD = 1'b1;
    JOY_CLK  = 1'b1;
    wait_clks(6);
    @(negedge clk);
    check("coincident_cnt", 32'(bit_cnt), 32'd0);
    check("coincident_data", 32'(JOY_DATA), 32'd0);
    JOY_CLK = 1'b0;
    wait_clks(6);

    // 5. joystick1 changes mid-frame; frame keeps the loaded word
    run_frame(12'h5A5, 12'hF0F, 24, 5, 12'hFFF, r1, r2);
    check("midchg_j1", 32'(r1), 32'h 5A5);
    check("midchg_j2", 32'(r2), 32'h F0F);

    // 6. reset after 10 clocks, then a clean frame
    run_frame(12'hFFF, 12'hFFF, 10, -1, 12'h000, r1, r2);
    Reset_I = 1'b0;
    wait_clks(2);
    @(negedge clk);
    check("midrst_data", 32'(JOY_DATA), 32'd1);
    check("midrst_cnt", 32'(bit_cnt), 32'd0);
    check("midrst_fd", 32'(frame_done), 32'd0);
    Reset_I = 1'b1;
    wait_clks(4);
    run_frame(12'h9C6, 12'h2B1, 24, -1, 12'h000, r1, r2);
    check("after_rst_j1", 32'(r1), 32'h 9C6);
    check("after_rst_j2", 32'(r2), 32'h 2B1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
